// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types for the iterative multiply/divide unit.
// Holds the FSM state, operation select and counter sizing helper.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic {
    OP_MULT,
    OP_DIV
  } op_e;

  // Counter must hold 0..WIDTH inclusive
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/multdiv_if.sv
// multdiv_if: operand/command/result bundle of the multdiv unit.
// data_remainder exists only when MULTDIV_REMAINDER_EN is defined.
interface multdiv_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic             ctrl_signed;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
`ifdef MULTDIV_REMAINDER_EN
  logic [WIDTH-1:0] data_remainder;
`endif

  modport master (
    output data_operandA,
    output data_operandB,
    output ctrl_MULT,
    output ctrl_DIV,
    output ctrl_signed,
    input  data_result,
    input  data_exception,
    input  data_resultRDY
`ifdef MULTDIV_REMAINDER_EN
    , input data_remainder
`endif
  );

  modport slave (
    input  data_operandA,
    input  data_operandB,
    input  ctrl_MULT,
    input  ctrl_DIV,
    input  ctrl_signed,
    output data_result,
    output data_exception,
    output data_resultRDY
`ifdef MULTDIV_REMAINDER_EN
    , output data_remainder
`endif
  );

endinterface

// File: rtl/multdiv_step.sv
// multdiv_step: one unsigned iteration of shift-add multiply
// (LSB first) or restoring shift-subtract divide (MSB first).
module multdiv_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH+1:0] diff;

  // Mult: acc:lo holds partial product, lo bit 0 picks the add.
  // Div: acc is the partial remainder, lo shifts dividend out
  // and quotient bits in.
  always_comb begin
    sum   = {1'b0, acc_i} + (lo_i[0] ? {1'b0, b_i} : '0);
    shl   = {acc_i, lo_i[WIDTH-1]};
    diff  = {1'b0, shl} - {2'b00, b_i};
    acc_o = acc_i;
    lo_o  = lo_i;
    unique case (op)
      OP_MULT: begin
        acc_o = sum[WIDTH:1];
        lo_o  = {sum[0], lo_i[WIDTH-1:1]};
      end
      OP_DIV: begin
        if (diff[WIDTH+1:WIDTH] == 2'b00) begin
          acc_o = diff[WIDTH-1:0];
          lo_o  = {lo_i[WIDTH-2:0], 1'b1};
        end else begin
          acc_o = shl[WIDTH-1:0];
          lo_o  = {lo_i[WIDTH-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multdiv_param.sv
// multdiv_param: iterative WIDTH-bit signed/unsigned mult/div.
// Define MULTDIV_REMAINDER_EN for the data_remainder output.
module multdiv_param
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clock,
  input  logic     reset_n,
  multdiv_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic             sgn_q, sgn_d;
  logic             neg_q, neg_d;
  logic             dexc_q, dexc_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
`ifdef MULTDIV_REMAINDER_EN
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] rem_q, rem_d;
`endif

  logic             start;
  logic             fin;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             a_min;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] sprod;
  logic [WIDTH:0]   hi_sign;
  logic             mul_exc;

  multdiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op    (op_q),
    .acc_i (acc_q),
    .lo_i  (lo_q),
    .b_i   (b_q),
    .acc_o (step_acc),
    .lo_o  (step_lo)
  );

  // Command decode and operand magnitudes
  always_comb begin
    start = bus.ctrl_MULT | bus.ctrl_DIV;
    fin   = (state_q == RUN) && (cnt_q == LAST);
    a_neg = bus.ctrl_signed & bus.data_operandA[WIDTH-1];
    b_neg = bus.ctrl_signed & bus.data_operandB[WIDTH-1];
    a_mag = a_neg ? -bus.data_operandA : bus.data_operandA;
    b_mag = b_neg ? -bus.data_operandB : bus.data_operandB;
    a_min = bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}};
  end

  // Signed product and overflow test on the finished product
  always_comb begin
    prod    = {acc_q, lo_q};
    sprod   = neg_q ? -prod : prod;
    hi_sign = sprod[2*WIDTH-1:WIDTH-1];
    if (sgn_q)
      mul_exc = ~((&hi_sign) | ~(|hi_sign));
    else
      mul_exc = |prod[2*WIDTH-1:WIDTH];
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state; a start wins over completion
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      start:                     state_d = RUN;
      !start && fin:             state_d = DONE;
      !start && state_q == DONE: state_d = IDLE;
      default: ;
    endcase
  end

  // Datapath, counter and result registers next values
  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    sgn_d  = sgn_q;
    neg_d  = neg_q;
    dexc_d = dexc_q;
    acc_d  = acc_q;
    lo_d   = lo_q;
    b_d    = b_q;
    res_d  = res_q;
    exc_d  = exc_q;
    rdy_d  = 1'b0;
`ifdef MULTDIV_REMAINDER_EN
    rneg_d = rneg_q;
    rem_d  = rem_q;
`endif
    if (fin) begin
      rdy_d = 1'b1;
      if (op_q == OP_MULT) begin
        res_d = sprod[WIDTH-1:0];
        exc_d = mul_exc;
`ifdef MULTDIV_REMAINDER_EN
        rem_d = sprod[2*WIDTH-1:WIDTH];
`endif
      end else if (dexc_q) begin
        res_d = '0;
        exc_d = 1'b1;
`ifdef MULTDIV_REMAINDER_EN
        rem_d = '0;
`endif
      end else begin
        res_d = neg_q ? -lo_q : lo_q;
        exc_d = 1'b0;
`ifdef MULTDIV_REMAINDER_EN
        rem_d = rneg_q ? -acc_q : acc_q;
`endif
      end
    end
    if (start) begin
      cnt_d  = '0;
      op_d   = bus.ctrl_MULT ? OP_MULT : OP_DIV;
      sgn_d  = bus.ctrl_signed;
      neg_d  = a_neg ^ b_neg;
      dexc_d = (bus.data_operandB == '0) |
               (bus.ctrl_signed & a_min &
                (&bus.data_operandB));
      acc_d  = '0;
      lo_d   = a_mag;
      b_d    = b_mag;
`ifdef MULTDIV_REMAINDER_EN
      rneg_d = a_neg;
`endif
    end else if (state_q == RUN && !fin) begin
      acc_d = step_acc;
      lo_d  = step_lo;
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Datapath and result registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      op_q   <= OP_MULT;
      sgn_q  <= 1'b0;
      neg_q  <= 1'b0;
      dexc_q <= 1'b0;
      acc_q  <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      res_q  <= '0;
      exc_q  <= 1'b0;
      rdy_q  <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
      rneg_q <= 1'b0;
      rem_q  <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      sgn_q  <= sgn_d;
      neg_q  <= neg_d;
      dexc_q <= dexc_d;
      acc_q  <= acc_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
      res_q  <= res_d;
      exc_q  <= exc_d;
      rdy_q  <= rdy_d;
`ifdef MULTDIV_REMAINDER_EN
      rneg_q <= rneg_d;
      rem_q  <= rem_d;
`endif
    end
  end

  assign bus.data_result    = res_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
`ifdef MULTDIV_REMAINDER_EN
  assign bus.data_remainder = rem_q;
`endif

endmodule

// File: tb/tb_multdiv_param.sv
// tb_multdiv_param: random + directed checks of multdiv_param
// at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_multdiv_param;

  typedef longint unsigned u64;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  multdiv_if #(.WIDTH(32)) if32 ();
  multdiv_if #(.WIDTH(8))  if8 ();

  multdiv_param #(.WIDTH(32)) dut32 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if32.slave)
  );

  multdiv_param #(.WIDTH(8)) dut8 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if8.slave)
  );

  task automatic check(input string tag, input u64 got,
                       input u64 exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic u64 res_of(input bit w8);
    return w8 ? u64'(if8.data_result) : u64'(if32.data_result);
  endfunction

  function automatic u64 exc_of(input bit w8);
    return w8 ? u64'(if8.data_exception)
              : u64'(if32.data_exception);
  endfunction

  function automatic bit rdy_of(input bit w8);
    return w8 ? if8.data_resultRDY : if32.data_resultRDY;
  endfunction

`ifdef MULTDIV_REMAINDER_EN
  function automatic u64 rem_of(input bit w8);
    return w8 ? u64'(if8.data_remainder)
              : u64'(if32.data_remainder);
  endfunction
`endif

  function automatic longint sx(input u64 x, input int w);
    u64 m = (64'd1 << w) - 64'd1;
    u64 v = x & m;
    if (v[w-1]) return longint'(v) - longint'(64'd1 << w);
    return longint'(v);
  endfunction

  // Arithmetic reference: full-precision product, truncating
  // division, remainder with the dividend's sign.
  function automatic void model(
    input int w, input bit mul, input bit sgn,
    input u64 a, input u64 b,
    output u64 res, output u64 rem, output bit exc);
    u64 m = (64'd1 << w) - 64'd1;
    u64 ua = a & m;
    u64 ub = b & m;
    longint sa = sgn ? sx(a, w) : longint'(ua);
    longint sb = sgn ? sx(b, w) : longint'(ub);
    longint sp;
    u64 up;
    res = 0;
    rem = 0;
    exc = 0;
    if (mul && sgn) begin
      sp  = sa * sb;
      res = u64'(sp) & m;
      rem = u64'(sp >>> w) & m;
      exc = sp != sx(u64'(sp), w);
    end else if (mul) begin
      up  = ua * ub;
      res = up & m;
      rem = (up >> w) & m;
      exc = (up >> w) != 0;
    end else if (ub == 0) begin
      exc = 1;
    end else if (sgn && sa == -(longint'(1) << (w - 1))
                 && sb == -1) begin
      exc = 1;
    end else if (sgn) begin
      res = u64'(sa / sb) & m;
      rem = u64'(sa % sb) & m;
    end else begin
      res = ua / ub;
      rem = ua % ub;
    end
  endfunction

  task automatic drive(input bit w8, input bit m, input bit d,
                       input bit s, input u64 a, input u64 b);
    if (w8) begin
      if8.ctrl_MULT     = m;
      if8.ctrl_DIV      = d;
      if8.ctrl_signed   = s;
      if8.data_operandA = a[7:0];
      if8.data_operandB = b[7:0];
    end else begin
      if32.ctrl_MULT     = m;
      if32.ctrl_DIV      = d;
      if32.ctrl_signed   = s;
      if32.data_operandA = a[31:0];
      if32.data_operandB = b[31:0];
    end
  endtask

  // Called at the negedge right after a start edge; returns the
  // number of edges until RDY is seen (bounded).
  task automatic wait_rdy(input bit w8, output int cyc);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!rdy_of(w8) && cyc < 200);
  endtask

  task automatic check_out(input string tag, input bit w8,
                           input bit mul, input bit sgn,
                           input u64 a, input u64 b);
    u64 er;
    u64 em;
    bit ee;
    model(w8 ? 8 : 32, mul, sgn, a, b, er, em, ee);
    check({tag, ".res"}, res_of(w8), er);
    check({tag, ".exc"}, exc_of(w8), u64'(ee));
`ifdef MULTDIV_REMAINDER_EN
    check({tag, ".rem"}, rem_of(w8), em);
`endif
  endtask

  task automatic run(input string tag, input bit w8,
                     input bit m, input bit d, input bit s,
                     input u64 a, input u64 b);
    int cyc;
    @(negedge clock);
    drive(w8, m, d, s, a, b);
    @(negedge clock);
    drive(w8, 0, 0, 0, 0, 0);
    wait_rdy(w8, cyc);
    check({tag, ".lat"}, u64'(cyc), w8 ? 64'd9 : 64'd33);
    check_out(tag, w8, m, s, a, b);
    @(negedge clock);
    check({tag, ".pulse"}, u64'(rdy_of(w8)), 0);
  endtask

  function automatic u64 rnd(input int w);
    u64 m = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 6))
      0:       return 0;
      1:       return 1;
      2:       return m;
      3:       return u64'(1) << (w - 1);
      4:       return u64'($urandom_range(0, 20));
      default: return u64'($urandom) & m;
    endcase
  endfunction

  initial begin
    int cyc;
    bit seen;
    bit m;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clock);
    check("rst.res", res_of(0), 0);
    check("rst.exc", exc_of(0), 0);
    check("rst.rdy", u64'(rdy_of(0)), 0);
`ifdef MULTDIV_REMAINDER_EN
    check("rst.rem", rem_of(0), 0);
`endif
    reset_n = 1'b1;

    run("smul_7x-6",    0, 1, 0, 1, 7, 32'hFFFF_FFFA);
    run("smul_ovf",     0, 1, 0, 1, 65536, 65536);
    run("umul_ffff",    0, 1, 0, 0, 32'hFFFF, 32'h1_0001);
    run("sdiv_-7/2",    0, 0, 1, 1, 32'hFFFF_FFF9, 2);
    run("udiv_max/2",   0, 0, 1, 0, 32'hFFFF_FFFF, 2);
    run("udiv_by0",     0, 0, 1, 0, 5, 0);
    run("sdiv_by0",     0, 0, 1, 1, 32'hFFFF_FFFB, 0);
    run("sdiv_min/-1",  0, 0, 1, 1, 32'h8000_0000,
        32'hFFFF_FFFF);
    run("w8_smul_min",  1, 1, 0, 1, 8'h80, 1);
    run("w8_smul_ovf",  1, 1, 0, 1, 16, 8);
    run("w8_sdiv_min",  1, 0, 1, 1, 8'h80, 8'hFF);
    run("w8_both",      1, 1, 1, 1, 8'hF3, 8'h05);

    for (int i = 0; i < 24; i++) begin
      m = $urandom_range(0, 1) == 1;
      run($sformatf("r32_%0d", i), 0, m, !m,
          $urandom_range(0, 1) == 1, rnd(32), rnd(32));
    end
    for (int i = 0; i < 24; i++) begin
      m = $urandom_range(0, 1) == 1;
      run($sformatf("r8_%0d", i), 1, m, !m,
          $urandom_range(0, 1) == 1, rnd(8), rnd(8));
    end

    // Restart: mult aborted by a div five edges later
    @(negedge clock);
    drive(0, 1, 0, 0, 3, 4);
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (rdy_of(0)) seen = 1;
    end
    drive(0, 0, 1, 0, 100, 7);
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0);
    wait_rdy(0, cyc);
    check("abort.early", u64'(seen), 0);
    check("abort.lat", u64'(cyc), 33);
    check("abort.q", res_of(0), 14);
    check_out("abort", 0, 0, 0, 100, 7);
    @(negedge clock);
    check("abort.pulse", u64'(rdy_of(0)), 0);

    // New start on the completion edge (WIDTH=8)
    @(negedge clock);
    drive(1, 1, 0, 1, 8'hF9, 8'h0B);
    @(negedge clock);
    drive(1, 0, 0, 0, 0, 0);
    repeat (8) @(negedge clock);
    drive(1, 0, 1, 0, 8'hC8, 8'h07);
    @(negedge clock);
    drive(1, 0, 0, 0, 0, 0);
    check("dedge.rdy", u64'(rdy_of(1)), 1);
    check_out("dedge.old", 1, 1, 1, 8'hF9, 8'h0B);
    wait_rdy(1, cyc);
    check("dedge.lat", u64'(cyc), 9);
    check_out("dedge.new", 1, 0, 0, 8'hC8, 8'h07);

    // Reset mid-RUN discards the op and clears outputs
    @(negedge clock);
    drive(0, 1, 0, 1, 7, 32'hFFFF_FFFA);
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0);
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (rdy_of(0)) seen = 1;
    end
    check("rstrun.rdy", u64'(seen), 0);
    check("rstrun.res", res_of(0), 0);
    check("rstrun.exc", exc_of(0), 0);
`ifdef MULTDIV_REMAINDER_EN
    check("rstrun.rem", rem_of(0), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
